// File: rtl/uart_pkg.sv
// Shared UART receive/transmit definitions.
// Holds oversample ratio, handshake byte codes and bit-state enum.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [7:0] ACK    = 8'hAA;
  localparam logic [7:0] RESEND = 8'hCC;

  typedef enum logic [2:0] {
    s_idle  = 3'd0,
    s_start = 3'd1,
    s_data  = 3'd2,
    s_stop  = 3'd3,
    s_break = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rcv_rx_byte.sv
// Byte-level UART receiver: synchronizer, bit FSM, shift register.
// Ports: clk, rst, rx_async_i in; rx_byte, rx_done, rx_ferr,
// rx_start, rx_state out (done/ferr/start valid in stop/idle cycle).
module uart_rx_byte
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_async_i,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_ferr,
  output logic       rx_start,
  output rx_state_e  rx_state
);

  logic       meta_q;
  logic       sync_q;
  rx_state_e  st_q;
  logic [3:0] sc_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      st_q   <= s_idle;
      sc_q   <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
    end else begin
      meta_q <= rx_async_i;
      sync_q <= meta_q;
      unique case (st_q)
        s_idle: begin
          if (!sync_q) begin
            st_q <= s_start;
            sc_q <= '0;
          end
        end
        s_start: begin
          sc_q <= sc_q + 4'd1;
          // mid-start re-check rejects short glitches
          if (sc_q == 4'd7) begin
            if (sync_q) begin
              st_q <= s_idle;
            end else begin
              st_q  <= s_data;
              sc_q  <= '0;
              bit_q <= '0;
            end
          end
        end
        s_data: begin
          sc_q <= sc_q + 4'd1;
          if (sc_q == 4'hF) begin
            sh_q  <= {sync_q, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) st_q <= s_stop;
          end
        end
        s_stop: begin
          sc_q <= sc_q + 4'd1;
          // leave mid-stop-bit so a following start is caught
          if (sc_q == 4'hF) st_q <= sync_q ? s_idle : s_break;
        end
        s_break: begin
          if (sync_q) st_q <= s_idle;
        end
        default: st_q <= s_idle;
      endcase
    end
  end

  assign rx_done  = (st_q == s_stop) && (sc_q == 4'hF);
  assign rx_ferr  = rx_done && !sync_q;
  assign rx_start = (st_q == s_idle) && !sync_q;
  assign rx_byte  = sh_q;
  assign rx_state = st_q;

endmodule

// File: rtl/uart_rcv.sv
// Packet layer: PKT_BYTES data bytes + XOR checksum, ack/resend, timeout.
// Ports: uart_sampling_clk, rst, USB_RX in; byte_data, byte_valid,
// pkt_valid, ack, resend, cs_rcv out (all registered).
module uart_rcv
  import uart_pkg::*;
#(
  parameter int PKT_BYTES = 81,
  parameter int TIMEOUT   = 4096
) (
  input  logic       uart_sampling_clk,
  input  logic       rst,
  input  logic       USB_RX,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       pkt_valid,
  output logic       ack,
  output logic       resend,
  output logic [2:0] cs_rcv
);

  localparam int BW = $clog2(PKT_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST = BW'(PKT_BYTES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_ferr;
  logic       rx_start;
  rx_state_e  rx_st;

  logic [BW-1:0] bi_q;
  logic [7:0]    acc_q;
  logic          err_q;
  logic [TW-1:0] tmo_q;

  uart_rx_byte u_rx (
    .clk        (uart_sampling_clk),
    .rst        (rst),
    .rx_async_i (USB_RX),
    .rx_byte    (rx_byte),
    .rx_done    (rx_done),
    .rx_ferr    (rx_ferr),
    .rx_start   (rx_start),
    .rx_state   (rx_st)
  );

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
      pkt_valid  <= 1'b0;
      ack        <= 1'b0;
      resend     <= 1'b0;
      bi_q       <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      byte_valid <= 1'b0;
      pkt_valid  <= 1'b0;
      ack        <= 1'b0;
      resend     <= 1'b0;
      if (rx_done) begin
        if (bi_q == LAST) begin
          // a framed-bad checksum byte also fails the packet
          if (!err_q && !rx_ferr && acc_q == rx_byte) begin
            ack       <= 1'b1;
            pkt_valid <= 1'b1;
          end else begin
            resend <= 1'b1;
          end
          bi_q  <= '0;
          acc_q <= '0;
          err_q <= 1'b0;
        end else begin
          byte_data  <= rx_byte;
          byte_valid <= 1'b1;
          acc_q      <= acc_q ^ rx_byte;
          bi_q       <= bi_q + 1'b1;
          err_q      <= err_q | rx_ferr;
        end
      end
      // rx_done only occurs outside idle, so no clash below
      if (rx_start) begin
        tmo_q <= '0;
      end else if (bi_q != '0 && rx_st == s_idle) begin
        if (tmo_q == TMAX) begin
          resend <= 1'b1;
          bi_q   <= '0;
          acc_q  <= '0;
          err_q  <= 1'b0;
          tmo_q  <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign cs_rcv = rx_st;

endmodule

// File: tb/tb_uart_rcv.sv
// Self-checking bench for uart_rcv with a packet-level model.
// PKT_BYTES=4, TIMEOUT=64; 16 sample ticks per serial bit.
module tb_uart_rcv;

  localparam int PB = 4;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       pkt_valid;
  logic       ack;
  logic       resend;
  logic [2:0] cs_rcv;

  int checks = 0;
  int errors = 0;
  int n_bv = 0, n_ack = 0, n_rs = 0;
  int s_bv = 0, s_ack = 0, s_rs = 0;

  // kind: 0 data byte, 1 ack, 2 resend
  typedef struct packed {
    logic [1:0] k;
    logic [7:0] d;
  } ev_t;

  ev_t        expq[$];
  int         mbi  = 0;
  logic [7:0] macc = 8'h00;
  bit         merr = 1'b0;

  uart_rcv #(.PKT_BYTES(PB), .TIMEOUT(TO)) dut (
    .uart_sampling_clk (clk),
    .rst               (rst),
    .USB_RX            (rx),
    .byte_data         (byte_data),
    .byte_valid        (byte_valid),
    .pkt_valid         (pkt_valid),
    .ack               (ack),
    .resend            (resend),
    .cs_rcv            (cs_rcv)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] xs(logic [7:0] a, logic [7:0] b,
                                    logic [7:0] c, logic [7:0] d);
    return a ^ b ^ c ^ d;
  endfunction

  // packet-level expectation for one received byte
  task automatic model_byte(logic [7:0] b, bit ferr);
    if (mbi < PB) begin
      expq.push_back(ev_t'{k: 2'd0, d: b});
      macc = macc ^ b;
      merr = merr | ferr;
      mbi++;
    end else begin
      if (!merr && !ferr && macc == b)
        expq.push_back(ev_t'{k: 2'd1, d: 8'h00});
      else
        expq.push_back(ev_t'{k: 2'd2, d: 8'h00});
      mbi  = 0;
      macc = 8'h00;
      merr = 1'b0;
    end
  endtask

  task automatic model_timeout();
    expq.push_back(ev_t'{k: 2'd2, d: 8'h00});
    mbi  = 0;
    macc = 8'h00;
    merr = 1'b0;
  endtask

  task automatic mon();
    ev_t        e;
    logic [1:0] k;
    forever begin
      @(negedge clk);
      if (!rst && (byte_valid || ack || resend || pkt_valid)) begin
        checks++;
        if ($countones({byte_valid, ack, resend}) > 1 ||
            pkt_valid !== ack) begin
          errors++;
          $display("FAIL strobes bv=%0b ack=%0b rs=%0b pv=%0b",
                   byte_valid, ack, resend, pkt_valid);
        end
        k = byte_valid ? 2'd0 : (ack ? 2'd1 : 2'd2);
        if (byte_valid) n_bv++;
        if (ack) n_ack++;
        if (resend) n_rs++;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL event got kind %0d data %h required none",
                   k, byte_data);
        end else begin
          e = expq.pop_front();
          if (e.k != k || (k == 2'd0 && e.d != byte_data)) begin
            errors++;
            $display("FAIL event got kind %0d data %h required kind %0d data %h",
                     k, byte_data, e.k, e.d);
          end
        end
      end
    end
  endtask

  task automatic tick(logic v, int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b, bit good);
    model_byte(b, !good);
    tick(1'b0, 16);
    for (int i = 0; i < 8; i++) tick(b[i], 16);
    if (good) begin
      tick(1'b1, 16);
    end else begin
      tick(1'b0, 20);
      chk("break_state", int'(cs_rcv), 4);
      tick(1'b0, 20);
      tick(1'b1, 16);
    end
  endtask

  task automatic send_pkt(logic [7:0] a, logic [7:0] b, logic [7:0] c,
                          logic [7:0] d, logic [7:0] cs, int bad);
    send_byte(a, bad != 1);
    send_byte(b, bad != 2);
    send_byte(c, bad != 3);
    send_byte(d, bad != 4);
    send_byte(cs, 1'b1);
  endtask

  task automatic snap();
    s_bv  = n_bv;
    s_ack = n_ack;
    s_rs  = n_rs;
  endtask

  task automatic expect_counts(string nm, int bv, int a, int r);
    tick(1'b1, 40);
    chk({nm, "_pending"}, expq.size(), 0);
    chk({nm, "_byte_valid"}, n_bv - s_bv, bv);
    chk({nm, "_ack"}, n_ack - s_ack, a);
    chk({nm, "_resend"}, n_rs - s_rs, r);
  endtask

  initial begin
    logic [7:0] pb;
    fork
      mon();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_byte_valid", int'(byte_valid), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_resend", int'(resend), 0);
    chk("rst_pkt_valid", int'(pkt_valid), 0);
    chk("rst_byte_data", int'(byte_data), 0);
    chk("rst_state", int'(cs_rcv), 0);
    rst = 1'b0;
    tick(1'b1, 20);

    // good packet
    chk("pin_cs1", int'(xs(8'h01, 8'h02, 8'h03, 8'h04)), 'h04);
    snap();
    send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 0);
    expect_counts("good", 4, 1, 0);

    // bad checksum
    snap();
    send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 0);
    expect_counts("badcs", 4, 0, 1);

    // start-bit glitch
    snap();
    tick(1'b0, 4);
    tick(1'b1, 30);
    chk("glitch_idle", int'(cs_rcv), 0);
    expect_counts("glitch", 0, 0, 0);
    chk("pin_cs2", int'(xs(8'h10, 8'h20, 8'h30, 8'h40)), 'h40);
    snap();
    send_pkt(8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 0);
    expect_counts("after_glitch", 4, 1, 0);

    // framing error on byte 2
    chk("pin_cs3", int'(xs(8'h11, 8'h22, 8'h33, 8'h44)), 'h44);
    snap();
    send_pkt(8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 2);
    expect_counts("ferr", 4, 0, 1);

    // inter-byte timeout
    snap();
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    model_timeout();
    tick(1'b1, 100);
    expect_counts("timeout", 2, 0, 1);
    snap();
    send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 0);
    expect_counts("after_timeout", 4, 1, 0);

    // reset during bit 5 of byte 3
    snap();
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    pb = 8'hC3;
    tick(1'b0, 16);
    for (int i = 0; i < 5; i++) tick(pb[i], 16);
    tick(pb[5], 8);
    rst = 1'b1;
    #1;
    chk("mid_rst_byte_valid", int'(byte_valid), 0);
    chk("mid_rst_ack", int'(ack), 0);
    chk("mid_rst_resend", int'(resend), 0);
    chk("mid_rst_pkt_valid", int'(pkt_valid), 0);
    chk("mid_rst_byte_data", int'(byte_data), 0);
    chk("mid_rst_state", int'(cs_rcv), 0);
    chk("pre_rst_pending", expq.size(), 0);
    chk("pre_rst_byte_valid", n_bv - s_bv, 2);
    expq.delete();
    mbi  = 0;
    macc = 8'h00;
    merr = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 20);
    chk("pin_cs4", int'(xs(8'hDE, 8'hAD, 8'hBE, 8'hEF)), 'h22);
    snap();
    send_pkt(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22, 0);
    expect_counts("after_rst", 4, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rcv.md
Name: uart_rcv

Overview:
Host-facing UART receiver that sits directly upstream of the ACK/RESEND transmitter. It samples USB_RX on the 16x uart_sampling_clk and assembles fixed-length packets of PKT_BYTES data bytes followed by one XOR checksum byte. It streams the data bytes to the solver-side loader. At packet end it issues a one-cycle ack pulse (good packet) or resend pulse (bad packet); these feed the transmitter's ack/resend inputs.

Parameters:
PKT_BYTES, 81, data bytes per packet (excluding the checksum byte); must be >= 1.
TIMEOUT, 4096, idle sample ticks allowed between bytes of a partially received packet before it is abandoned.

Ports:
uart_sampling_clk  input  1  16x baud sampling clock; the only clock.
rst  input  1  asynchronous, active-high reset.
USB_RX  input  1  serial line from host; idles high; asynchronous to the clock.
byte_data  output  8  received data byte.
byte_valid  output  1  one-cycle strobe; byte_data is valid (data bytes only, never the checksum byte).
pkt_valid  output  1  one-cycle strobe; packet passed all checks; same cycle as ack.
ack  output  1  one-cycle pulse on good packet.
resend  output  1  one-cycle pulse on bad or abandoned packet.
cs_rcv  output  3  current bit-level state, for debug.

Behaviour:
- Reset (async): state s_idle; sync flops = 1; byte_data = 0; byte_valid, pkt_valid, ack, resend = 0; byte count, XOR accumulator, error flag and timeout counter = 0.
- USB_RX passes through a 2-flop synchronizer before any use. All references to RX below mean the synchronized value.
- Bit-level FSM with sample counter sc (4 bits, wraps):
  - s_idle: RX == 0 → go to s_start and set sc = 0.
  - s_start: sc increments each tick. At sc == 7, check RX. If RX == 1 it was a glitch: return to s_idle with no byte and no error. If RX == 0, set sc = 0 and go to s_data.
  - s_data: sample RX when sc == 15. Shift it in LSB-first and increment the bit counter. After the 8th bit, go to s_stop.
  - s_stop: sample at sc == 15. RX == 1 means the byte is complete; go to s_idle. RX == 0 is a framing error: set the packet error flag, the byte still counts, and go to s_break.
  - s_break: wait for RX == 1, then go to s_idle. No start detection occurs while in s_break.
- Byte-complete cycle = the cycle of the stop-bit sample. All outputs are registered and appear on the next cycle.
- Packet layer, with byte index bi running 0..PKT_BYTES:
  - For bi < PKT_BYTES: byte_data and byte_valid are driven, the byte is XORed into the accumulator, and bi increments.
  - For bi == PKT_BYTES (checksum byte): no byte_valid. ack and pkt_valid are asserted if error flag == 0 and accumulator == checksum byte; otherwise resend. Then bi, accumulator and error flag are cleared.
- Timeout:
  - The counter runs only while bi != 0 and the FSM is in s_idle. It clears on every start detection.
  - When it reaches TIMEOUT-1: pulse resend and clear bi, accumulator and error flag. No ack is issued.
- ack and resend are never asserted in the same cycle. Neither is asserted more than once per packet.
- Back-to-back bytes: s_idle is re-entered mid-stop-bit, so a start bit immediately after the stop bit is accepted with no lost bytes.
- Reset mid-byte or mid-packet: the partial byte and packet are discarded with no pulses. After reset, the next falling edge begins a fresh byte with bi = 0.
- Host bytes are assumed to follow the protocol. Bit timing tolerates up to ±3 sample ticks of cumulative drift per byte.

Decomposition:
- Package uart_pkg holds:
  - OVERSAMPLE = 16;
  - ACK = 8'hAA and RESEND = 8'hCC, shared with the transmitter;
  - the bit-state enum {s_idle, s_start, s_data, s_stop, s_break}.
- Sub-module uart_rx_byte contains the synchronizer, the bit FSM and the shift register. Its outputs are rx_byte[7:0], rx_done and rx_ferr.
- uart_rcv instantiates uart_rx_byte and implements the packet and checksum layer plus the timeout.

Test Plan:
- PKT_BYTES=4. Send 01 02 03 04 with checksum 04 (back-to-back, 16 ticks per bit) → four byte_valid strobes with data 01..04, then ack = pkt_valid = 1 for exactly one cycle; resend stays 0.
- Same packet with checksum 05 → four byte_valid strobes, then resend for one cycle; ack and pkt_valid stay 0.
- Drive USB_RX low for 4 ticks, then high → no byte_valid; FSM returns to s_idle; the following valid packet acks.
- Drive byte 2 with stop bit = 0 and hold low 40 ticks before releasing; checksum otherwise correct → FSM passes through s_break; resend at packet end; no ack.
- TIMEOUT=64. Send 2 bytes, then idle 64 ticks → resend for one cycle. A subsequent full 4+1 packet starts at bi = 0 and acks.
- Assert rst during bit 5 of byte 3 → all outputs 0 immediately. A fresh full packet after reset acks, with byte_valid data matching the new bytes only.
